// File: rtl/conv_output_writer.sv
// conv_output_writer: buffers the (data, x, y, ch) result stream and writes each word to external
//   memory at a CHW or HWC address. Counts written words; done rises once the whole map is stored.
// Latency: a word accepted in cycle N is presented on mem_* in cycle N+1 when the FIFO was empty.
// Backpressure: in_ready = RUN && FIFO not full, both registered; mem_ready only pops the FIFO head.
// Ports: clk, arst_n_in (async, active low) | start pulse | in_data/in_x/in_y/in_ch + in_valid/in_ready
//   | mem_we/mem_addr/mem_wdata + mem_ready | count, error_oob (sticky), done.

// Small generic FIFO: DEPTH is a power of two, pointers wrap naturally.
// Latency: head_dat shows an entry the cycle after it is pushed.
// Backpressure: a push while full is refused, even if a pop happens in the same cycle.
module conv_output_writer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: nothing is read while level is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module conv_output_writer #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int EXT_MEM_ADDR_WIDTH = 20,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int FIFO_DEPTH         = 4,
  parameter int BASE_ADDR          = 0,
  parameter int LAYOUT             = 0,
  localparam int X_W   = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int Y_W   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int CH_W  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
  localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int CNT_W = $clog2(TOTAL + 1)
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic [CH_W-1:0]               in_ch,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          mem_we,
  output logic [EXT_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [EXT_MEM_WIDTH-1:0]      mem_wdata,
  input  logic                          mem_ready,
  output logic [CNT_W-1:0]              count,
  output logic                          error_oob,
  output logic                          done
);
  localparam int AW      = EXT_MEM_ADDR_WIDTH;
  localparam int DW      = EXT_MEM_WIDTH;
  localparam int ENTRY_W = AW + DW;
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               error_oob_q, error_oob_d;
  logic               done_q, done_d;

  logic               hs, in_range, push, pop;
  logic               fifo_empty, fifo_full;
  logic [LVL_W-1:0]   fifo_level;
  logic [AW-1:0]      x_a, y_a, ch_a, addr_calc;
  logic [DW-1:0]      data_ext;
  logic [ENTRY_W-1:0] push_dat, head_dat;

  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign hs       = in_valid && in_ready;
  assign in_range = (int'(in_x)  < FEATURE_MAP_WIDTH) &&
                    (int'(in_y)  < FEATURE_MAP_HEIGHT) &&
                    (int'(in_ch) < OUTPUT_NB_CHANNELS);
  // Out-of-range words complete the handshake but never enter the FIFO.
  assign push     = hs && in_range;
  assign pop      = !fifo_empty && mem_ready;

  // Address arithmetic runs at the memory address width so it wraps like the memory does.
  assign x_a  = AW'(in_x);
  assign y_a  = AW'(in_y);
  assign ch_a = AW'(in_ch);

  always_comb begin
    if (LAYOUT == 0)
      addr_calc = AW'(BASE_ADDR) + (ch_a * AW'(FEATURE_MAP_HEIGHT) + y_a) * AW'(FEATURE_MAP_WIDTH) + x_a;
    else
      addr_calc = AW'(BASE_ADDR) + (y_a * AW'(FEATURE_MAP_WIDTH) + x_a) * AW'(OUTPUT_NB_CHANNELS) + ch_a;
  end

  assign data_ext = DW'($signed(in_data));
  assign push_dat = {addr_calc, data_ext};

  conv_output_writer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (pop),
    .head_dat  (head_dat),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Head is masked while empty so the write port idles at zero.
  assign mem_we    = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : head_dat[ENTRY_W-1 -: AW];
  assign mem_wdata = fifo_empty ? '0 : head_dat[DW-1:0];

  always_comb begin
    state_d     = state_q;
    accepted_d  = accepted_q;
    count_d     = count_q;
    error_oob_d = error_oob_q;

    if (pop && (count_q != CNT_W'(TOTAL))) count_d = count_q + CNT_W'(1);
    if (hs && !in_range)                   error_oob_d = 1'b1;
    if (push)                              accepted_d = accepted_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          accepted_d  = '0;
          count_d     = '0;
          error_oob_d = 1'b0;
        end
      end
      // Leave RUN on the cycle the final in-range word is accepted so in_ready drops at once.
      ST_RUN: begin
        if (accepted_d == CNT_W'(TOTAL)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty || (pop && (fifo_level == LVL_W'(1)))) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= ST_IDLE;
      accepted_q  <= '0;
      count_q     <= '0;
      error_oob_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      accepted_q  <= accepted_d;
      count_q     <= count_d;
      error_oob_q <= error_oob_d;
      done_q      <= done_d;
    end
  end

  assign count     = count_q;
  assign error_oob = error_oob_q;
  assign done      = done_q;
endmodule

// File: tb/tb_conv_output_writer.sv
// tb_conv_output_writer: drives three writers (CHW 4x2x2, HWC 4x2x2, CHW 3x2x2 for range errors)
//   and scoreboards every memory write against addresses computed from the layout formulas.
// Latency/backpressure are observed through the write-port monitor and in_ready.
`timescale 1ns/1ps
module tb_conv_output_writer;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int H  = 2;
  localparam int C  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, start, in_valid, mr;
  logic        start_m, start_o, vld_m, vld_o;
  logic [31:0] in_data;
  logic [1:0]  in_x;
  logic        in_y, in_ch;
  int          sel;  // 0: the two 4x2x2 writers, 1: the 3x2x2 writer

  logic          rdy [3];
  logic          we  [3];
  logic [AW-1:0] addr[3];
  logic [DW-1:0] wdat[3];
  logic [4:0]    cnt [3];
  logic [3:0]    cnt_o;
  logic          err [3];
  logic          dn  [3];

  assign start_m = start && (sel == 0);
  assign start_o = start && (sel == 1);
  assign vld_m   = in_valid && (sel == 0);
  assign vld_o   = in_valid && (sel == 1);
  assign cnt[2]  = {1'b0, cnt_o};

  conv_output_writer #(.FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2),
    .FIFO_DEPTH(4), .BASE_ADDR('h100), .LAYOUT(0)) u_chw (
    .clk(clk), .arst_n_in(arst_n), .start(start_m), .in_data(in_data), .in_x(in_x), .in_y(in_y),
    .in_ch(in_ch), .in_valid(vld_m), .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdat[0]), .mem_ready(mr), .count(cnt[0]), .error_oob(err[0]), .done(dn[0]));

  conv_output_writer #(.FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2),
    .FIFO_DEPTH(4), .BASE_ADDR('h100), .LAYOUT(1)) u_hwc (
    .clk(clk), .arst_n_in(arst_n), .start(start_m), .in_data(in_data), .in_x(in_x), .in_y(in_y),
    .in_ch(in_ch), .in_valid(vld_m), .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdat[1]), .mem_ready(mr), .count(cnt[1]), .error_oob(err[1]), .done(dn[1]));

  conv_output_writer #(.FEATURE_MAP_WIDTH(3), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2),
    .FIFO_DEPTH(4), .BASE_ADDR('h100), .LAYOUT(0)) u_oob (
    .clk(clk), .arst_n_in(arst_n), .start(start_o), .in_data(in_data), .in_x(in_x), .in_y(in_y),
    .in_ch(in_ch), .in_valid(vld_o), .in_ready(rdy[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_wdata(wdat[2]), .mem_ready(mr), .count(cnt_o), .error_oob(err[2]), .done(dn[2]));

  // Reference model: per-writer geometry, expected write queue and words written since start.
  int          wd [3] = '{4, 4, 3};
  int          lay[3] = '{0, 1, 0};
  int          tot[3] = '{16, 16, 12};
  logic [51:0] expq[3][$];
  int          written[3] = '{0, 0, 0};
  bit          chk_done[3] = '{0, 0, 0};
  int          n_chk = 0;
  int          n_pass = 0;
  bit          rand_mr = 1'b0;

  int          px[16], py[16], pc[16];
  logic [31:0] pd[16];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail(string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endfunction

  function automatic logic [51:0] entry(int d, int x, int y, int ch, logic [31:0] v);
    int a;
    if (lay[d] == 0) a = 'h100 + (ch * H + y) * wd[d] + x;
    else             a = 'h100 + (y * wd[d] + x) * C + ch;
    return {a[19:0], v};
  endfunction

  function automatic void model_accept(int x, int y, int ch, logic [31:0] v);
    for (int d = 0; d < 3; d++)
      if (((d < 2) == (sel == 0)) && x < wd[d] && y < H && ch < C)
        expq[d].push_back(entry(d, x, y, ch, v));
  endfunction

  // Write-port monitor: every presented write must match the queue head; a taken write pops it.
  always @(negedge clk) begin
    logic [51:0] e;
    if (arst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (chk_done[d]) begin
          chk_done[d] = 1'b0;
          check($sformatf("done_after_last_write[%0d]", d), dn[d], 1);
          check($sformatf("count_final[%0d]", d), cnt[d], tot[d]);
        end
        if (we[d]) begin
          if (expq[d].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write[%0d]: addr 0x%0h, no write expected", d, addr[d]);
          end else begin
            e = expq[d][0];
            check($sformatf("wr_addr[%0d]", d), addr[d], e[51:32]);
            check($sformatf("wr_data[%0d]", d), wdat[d], e[31:0]);
            if (mr) begin
              check($sformatf("count_before_write[%0d]", d), cnt[d], written[d]);
              check($sformatf("done_low_while_writing[%0d]", d), dn[d], 0);
              void'(expq[d].pop_front());
              written[d]++;
              if (written[d] == tot[d]) chk_done[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mr) begin
      #1;
      mr = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic build(input bit shuffle);
    int i = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 4; x++) begin
          px[i] = x; py[i] = y; pc[i] = ch;
          pd[i] = (x == 3 && y == 1 && ch == 1) ? 32'hFFFF_FFFB : $urandom;
          i++;
        end
    if (shuffle)
      for (int j = 15; j > 0; j--) begin
        int k, tx, ty, tc;
        logic [31:0] td;
        k = $urandom_range(0, j);
        tx = px[j]; ty = py[j]; tc = pc[j]; td = pd[j];
        px[j] = px[k]; py[j] = py[k]; pc[j] = pc[k]; pd[j] = pd[k];
        px[k] = tx; py[k] = ty; pc[k] = tc; pd[k] = td;
      end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int x, input int y, input int ch, input logic [31:0] v, input int gap);
    int cyc = 0;
    bit ok = 1'b0;
    if (gap > 0) begin
      repeat ($urandom_range(0, gap)) @(posedge clk);
      #1;
    end
    in_x = 2'(x); in_y = 1'(y); in_ch = 1'(ch); in_data = v; in_valid = 1'b1;
    while (!ok && cyc < 100) begin
      @(negedge clk);
      if ((sel == 0) ? rdy[0] : rdy[2]) ok = 1'b1;
      else cyc++;
    end
    if (ok) model_accept(x, y, ch, v);
    else fail("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    for (int d = 0; d < 3; d++)
      if ((d < 2) == (sel == 0)) written[d] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 3; d++)
      if ((d < 2) == (sel == 0)) begin
        check($sformatf("start_clears_count[%0d]", d), cnt[d], 0);
        check($sformatf("start_clears_done[%0d]", d), dn[d], 0);
        check($sformatf("start_clears_err[%0d]", d), err[d], 0);
      end
  endtask

  task automatic wait_written(input int d, input int n);
    int cyc = 0;
    while (written[d] < n && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    if (written[d] < n) fail($sformatf("write_wait[%0d]", d));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_in_ready[%0d]", tag, d), rdy[d], 0);
      check($sformatf("%s_mem_we[%0d]", tag, d), we[d], 0);
      check($sformatf("%s_mem_addr[%0d]", tag, d), addr[d], 0);
      check($sformatf("%s_mem_wdata[%0d]", tag, d), wdat[d], 0);
      check($sformatf("%s_count[%0d]", tag, d), cnt[d], 0);
      check($sformatf("%s_error_oob[%0d]", tag, d), err[d], 0);
      check($sformatf("%s_done[%0d]", tag, d), dn[d], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, acc;
    arst_n = 1'b1; start = 1'b0; in_valid = 1'b0; mr = 1'b1; sel = 0;
    in_x = '0; in_y = 1'b0; in_ch = 1'b0; in_data = '0;
    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Full map in raster order, memory always ready.
    build(1'b0);
    start_pulse();
    for (int i = 0; i < 16; i++) send(px[i], py[i], pc[i], pd[i], 0);
    wait_written(0, 16);
    wait_written(1, 16);
    check("done_held_chw", dn[0], 1);
    check("done_held_hwc", dn[1], 1);
    check("in_ready_low_done", rdy[0], 0);

    // Restart from DONE: shuffled order, random memory stalls and input gaps.
    build(1'b1);
    start_pulse();
    rand_mr = 1'b1;
    for (int i = 0; i < 16; i++) send(px[i], py[i], pc[i], pd[i], 2);
    wait_written(0, 16);
    wait_written(1, 16);
    rand_mr = 1'b0;
    @(posedge clk); #2 mr = 1'b1;
    check("err_clear_clean_run", err[0], 0);

    // Memory stalled for 10 cycles with input continuously valid.
    build(1'b1);
    mr = 1'b0;
    start_pulse();
    k = 0; acc = 0;
    in_x = 2'(px[0]); in_y = 1'(py[0]); in_ch = 1'(pc[0]); in_data = pd[0]; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rdy[0]) begin
        model_accept(px[k], py[k], pc[k], pd[k]);
        acc++; k++;
      end
      @(posedge clk); #1;
      in_x = 2'(px[k]); in_y = 1'(py[k]); in_ch = 1'(pc[k]); in_data = pd[k];
    end
    check("stall_accepts", acc, 4);
    check("stall_in_ready", rdy[0], 0);
    check("stall_count", cnt[0], 0);
    mr = 1'b1;
    for (int i = k; i < 16; i++) send(px[i], py[i], pc[i], pd[i], 0);
    wait_written(0, 16);
    wait_written(1, 16);

    // Out-of-range column on the 3-wide writer.
    sel = 1;
    start_pulse();
    for (int ch = 0; ch < 2; ch++)
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 3; x++) begin
          send(x, y, ch, $urandom, 1);
          if (ch == 0 && y == 1 && x == 0) begin
            check("err_before_oob", err[2], 0);
            send(3, y, ch, 32'h1234_5678, 0);
            check("err_after_oob", err[2], 1);
          end
        end
    wait_written(2, 12);
    check("err_sticky", err[2], 1);
    start_pulse();

    // Reset with writes pending, then a clean full run.
    sel = 0;
    build(1'b1);
    start_pulse();
    for (int i = 0; i < 7; i++) send(px[i], py[i], pc[i], pd[i], 0);
    wait_written(0, 7);
    mr = 1'b0;
    send(px[7], py[7], pc[7], pd[7], 0);
    send(px[8], py[8], pc[8], pd[8], 0);
    #1 arst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      expq[d].delete();
      written[d] = 0;
      chk_done[d] = 1'b0;
    end
    #1 check_reset_vals("midrun_reset");
    repeat (2) @(posedge clk);
    #1 mr = 1'b1;
    arst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("no_write_after_reset", we[0], 0);
    start_pulse();
    for (int i = 0; i < 16; i++) send(px[i], py[i], pc[i], pd[i], 0);
    wait_written(0, 16);
    wait_written(1, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
